exc_commit: RTL and testbench

EXC_COMMIT -- requirements
Module: exc_commit

---
 rtl/exc_commit.sv | 186 ++++++++++++++++++
 tb/tb_exc_commit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/exc_commit.sv
// Exception commit stage: picks the highest-priority cause, reports it to CP0 and redirects the front end.
// Optional macro EXC_TLB_EN enables decoding of the TLB/Mod cause bits 10-16.
module exc_commit #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] exception_vector_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] badvaddr_i,
  input  logic        bd_i,
  input  logic        cp0_bev_i,
  input  logic        cp0_exl_i,
  input  logic [31:0] cp0_epc_i,
  output logic        commit_valid_o,
  output logic        exc_valid_o,
  output logic [4:0]  exc_code_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic        bd_o,
  output logic        eret_o,
  output logic        flush_o,
  output logic [31:0] target_pc_o
);

  typedef enum logic [1:0] {S_IDLE, S_REPORT, S_FLUSH} state_e;

`ifdef EXC_TLB_EN
  localparam logic [31:0] LIVE_MASK = 32'h8007_FFFF;
  localparam bit          TLB_EN    = 1'b1;
`else
  localparam logic [31:0] LIVE_MASK = 32'h8006_03FF;
  localparam bit          TLB_EN    = 1'b0;
`endif

  localparam int unsigned PRIO_N = 20;
  localparam logic [4:0] PRIO [PRIO_N] = '{
    5'd0, 5'd1, 5'd10, 5'd11, 5'd18, 5'd17, 5'd5, 5'd6, 5'd7, 5'd2,
    5'd3, 5'd8, 5'd9, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd4, 5'd31
  };
  // REPORT is the first flush cycle, so the counter holds the cycles left after it.
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  logic [31:0] live;
  logic [4:0]  win;
  logic        win_found;
  logic [4:0]  win_code;
  logic        is_eret, is_refetch, is_fetch, is_refill;
  logic [31:0] vec_target;

  always_comb begin
    live      = exception_vector_i & LIVE_MASK;
    win       = 5'd0;
    win_found = 1'b0;
    // Scan lowest priority first so the highest-priority live cause is written last.
    for (int i = PRIO_N - 1; i >= 0; i--) begin
      if (live[PRIO[i]]) begin
        win       = PRIO[i];
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    case (win)
      5'd0:                      win_code = 5'h00;
      5'd16:                     win_code = 5'h01;
      5'd10, 5'd11, 5'd12, 5'd14: win_code = 5'h02;
      5'd13, 5'd15:              win_code = 5'h03;
      5'd1, 5'd8:                win_code = 5'h04;
      5'd9:                      win_code = 5'h05;
      5'd2:                      win_code = 5'h08;
      5'd3:                      win_code = 5'h09;
      5'd5:                      win_code = 5'h0A;
      5'd17, 5'd18:              win_code = 5'h0B;
      5'd6:                      win_code = 5'h0C;
      5'd7:                      win_code = 5'h0D;
      default:                   win_code = 5'h00;
    endcase
    is_eret    = (win == 5'd4);
    is_refetch = (win == 5'd31);
    is_fetch   = (win == 5'd1) || (win == 5'd10) || (win == 5'd11);
    is_refill  = TLB_EN && !cp0_exl_i && ((win == 5'd10) || (win == 5'd12) || (win == 5'd13));
    vec_target = (cp0_bev_i ? 32'hBFC0_0200 : 32'h8000_0000) + (is_refill ? 32'h0 : 32'h180);
  end

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d, flush_q, flush_d;
  logic        commit_valid_q, commit_valid_d, exc_valid_q, exc_valid_d, eret_q, eret_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d, badvaddr_q, badvaddr_d, target_pc_q, target_pc_d;
  logic        bd_q, bd_d;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ready_d        = ready_q;
    flush_d        = flush_q;
    commit_valid_d = 1'b0;
    exc_valid_d    = 1'b0;
    eret_d         = 1'b0;
    exc_code_d     = exc_code_q;
    epc_d          = epc_q;
    badvaddr_d     = badvaddr_q;
    bd_d           = bd_q;
    target_pc_d    = target_pc_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i && ready_q) begin
          if (!win_found) begin
            commit_valid_d = 1'b1;
          end else begin
            state_d     = S_REPORT;
            cnt_d       = CNT_INIT;
            ready_d     = 1'b0;
            flush_d     = 1'b1;
            exc_valid_d = !is_eret && !is_refetch;
            eret_d      = is_eret;
            exc_code_d  = (is_eret || is_refetch) ? 5'h00 : win_code;
            epc_d       = bd_i ? pc_i - 32'd4 : pc_i;
            badvaddr_d  = is_fetch ? pc_i : badvaddr_i;
            bd_d        = bd_i;
            target_pc_d = is_eret ? cp0_epc_i : (is_refetch ? pc_i : vec_target);
          end
        end
      end
      S_REPORT, S_FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          flush_d = 1'b0;
        end else begin
          state_d = S_FLUSH;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      cnt_q          <= 4'd0;
      ready_q        <= 1'b1;
      flush_q        <= 1'b0;
      commit_valid_q <= 1'b0;
      exc_valid_q    <= 1'b0;
      eret_q         <= 1'b0;
      exc_code_q     <= 5'h00;
      epc_q          <= 32'h0;
      badvaddr_q     <= 32'h0;
      bd_q           <= 1'b0;
      target_pc_q    <= 32'h0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ready_q        <= ready_d;
      flush_q        <= flush_d;
      commit_valid_q <= commit_valid_d;
      exc_valid_q    <= exc_valid_d;
      eret_q         <= eret_d;
      exc_code_q     <= exc_code_d;
      epc_q          <= epc_d;
      badvaddr_q     <= badvaddr_d;
      bd_q           <= bd_d;
      target_pc_q    <= target_pc_d;
    end
  end

  assign ready_o        = ready_q;
  assign flush_o        = flush_q;
  assign commit_valid_o = commit_valid_q;
  assign exc_valid_o    = exc_valid_q;
  assign eret_o         = eret_q;
  assign exc_code_o     = exc_code_q;
  assign epc_o          = epc_q;
  assign badvaddr_o     = badvaddr_q;
  assign bd_o           = bd_q;
  assign target_pc_o    = target_pc_q;

endmodule

// File: tb/tb_exc_commit.sv
// Self-checking bench for exc_commit: directed scenarios plus randomized transactions against a priority-list model.
module tb_exc_commit;

  localparam int FC = 2;
`ifdef EXC_TLB_EN
  localparam bit TLB_ON = 1'b1;
`else
  localparam bit TLB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] exception_vector_i, pc_i, badvaddr_i, cp0_epc_i;
  logic        bd_i, cp0_bev_i, cp0_exl_i;
  logic        commit_valid_o, exc_valid_o, bd_o, eret_o, flush_o;
  logic [4:0]  exc_code_o;
  logic [31:0] epc_o, badvaddr_o, target_pc_o;

  int passed = 0;
  int total  = 0;

  exc_commit #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .resetn(resetn), .valid_i(valid_i), .ready_o(ready_o),
    .exception_vector_i(exception_vector_i), .pc_i(pc_i), .badvaddr_i(badvaddr_i), .bd_i(bd_i),
    .cp0_bev_i(cp0_bev_i), .cp0_exl_i(cp0_exl_i), .cp0_epc_i(cp0_epc_i),
    .commit_valid_o(commit_valid_o), .exc_valid_o(exc_valid_o), .exc_code_o(exc_code_o),
    .epc_o(epc_o), .badvaddr_o(badvaddr_o), .bd_o(bd_o), .eret_o(eret_o),
    .flush_o(flush_o), .target_pc_o(target_pc_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        commit;
    logic        exc;
    logic        eret;
    logic [4:0]  code;
    logic [31:0] target;
    logic [31:0] epc;
    logic [31:0] bva;
    logic        bd;
  } exp_t;

  function automatic logic [4:0] code_of(input int cause);
    case (cause)
      0: return 5'h00;   1: return 5'h04;   2: return 5'h08;   3: return 5'h09;
      5: return 5'h0A;   6: return 5'h0C;   7: return 5'h0D;   8: return 5'h04;
      9: return 5'h05;   10: return 5'h02;  11: return 5'h02;  12: return 5'h02;
      13: return 5'h03;  14: return 5'h02;  15: return 5'h03;  16: return 5'h01;
      17: return 5'h0B;  18: return 5'h0B;
      default: return 5'h00;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] vec, pc, bva, input logic bd, bev, exl,
                                 input logic [31:0] epc);
    int    prio [20];
    int    w;
    exp_t  e;
    prio = '{0, 1, 10, 11, 18, 17, 5, 6, 7, 2, 3, 8, 9, 12, 13, 14, 15, 16, 4, 31};
    w = -1;
    foreach (prio[i])
      if (w < 0 && vec[prio[i]] && (TLB_ON || prio[i] < 10 || prio[i] > 16)) w = prio[i];
    e.commit = (w < 0);
    e.eret   = (w == 4);
    e.exc    = (w >= 0) && (w != 4) && (w != 31);
    e.code   = code_of(w);
    if (w == 4)       e.target = epc;
    else if (w == 31) e.target = pc;
    else e.target = (bev ? 32'hBFC0_0200 : 32'h8000_0000) +
                    ((TLB_ON && !exl && (w == 10 || w == 12 || w == 13)) ? 32'h0 : 32'h180);
    e.epc = bd ? pc - 32'd4 : pc;
    e.bva = (w == 1 || w == 10 || w == 11) ? pc : bva;
    e.bd  = bd;
    return e;
  endfunction

  // Drives one transaction starting at a negedge with ready_o high; returns at a negedge with ready_o high.
  task automatic exercise(input logic [31:0] vec, pc, bva, input logic bd, bev, exl,
                          input logic [31:0] epc, input string tag);
    exp_t e;
    int   n, extra;
    e = model(vec, pc, bva, bd, bev, exl, epc);
    total++; if (ready_o !== 1'b1) $display("FAIL %s ready_before: got %b want 1", tag, ready_o); else passed++;
    valid_i = 1'b1; exception_vector_i = vec; pc_i = pc; badvaddr_i = bva;
    bd_i = bd; cp0_bev_i = bev; cp0_exl_i = exl; cp0_epc_i = epc;
    @(negedge clk);
    valid_i = 1'b0;
    if (e.commit) begin
      total++; if (commit_valid_o !== 1'b1) $display("FAIL %s commit_valid: got %b want 1", tag, commit_valid_o); else passed++;
      total++; if ({flush_o, exc_valid_o, eret_o, ready_o} !== 4'b0001)
        $display("FAIL %s commit_ctrl: got %b want 0001", tag, {flush_o, exc_valid_o, eret_o, ready_o}); else passed++;
    end else begin
      total++; if ({commit_valid_o, exc_valid_o, eret_o, flush_o, ready_o} !== {1'b0, e.exc, e.eret, 2'b10})
        $display("FAIL %s report_ctrl: got %b want %b", tag, {commit_valid_o, exc_valid_o, eret_o, flush_o, ready_o},
                 {1'b0, e.exc, e.eret, 2'b10}); else passed++;
      total++; if (target_pc_o !== e.target) $display("FAIL %s target: got %h want %h", tag, target_pc_o, e.target); else passed++;
      total++; if ({epc_o, badvaddr_o, bd_o} !== {e.epc, e.bva, e.bd})
        $display("FAIL %s epc_bva_bd: got %h %h %b want %h %h %b", tag, epc_o, badvaddr_o, bd_o, e.epc, e.bva, e.bd); else passed++;
      if (e.exc) begin
        total++; if (exc_code_o !== e.code) $display("FAIL %s exc_code: got %h want %h", tag, exc_code_o, e.code); else passed++;
      end
      // Offer junk while stalled; none of it may be captured.
      valid_i = 1'b1; exception_vector_i = $urandom; pc_i = $urandom; badvaddr_i = $urandom;
      bd_i = ~bd; cp0_epc_i = $urandom;
      n = 1; extra = 0;
      for (int k = 0; k < 20 && flush_o === 1'b1; k++) begin
        @(negedge clk);
        if (flush_o === 1'b1) n++;
        if (exc_valid_o !== 1'b0 || eret_o !== 1'b0 || commit_valid_o !== 1'b0) extra++;
      end
      valid_i = 1'b0;
      total++; if (n !== FC) $display("FAIL %s flush_len: got %0d want %0d", tag, n, FC); else passed++;
      total++; if (extra !== 0) $display("FAIL %s stray_pulse: got %0d want 0", tag, extra); else passed++;
      total++; if ({target_pc_o, epc_o, bd_o} !== {e.target, e.epc, e.bd})
        $display("FAIL %s hold: got %h %h %b want %h %h %b", tag, target_pc_o, epc_o, bd_o, e.target, e.epc, e.bd); else passed++;
      total++; if (ready_o !== 1'b1) $display("FAIL %s ready_after: got %b want 1", tag, ready_o); else passed++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; valid_i = 1'b0; exception_vector_i = '0; pc_i = '0; badvaddr_i = '0;
    bd_i = 1'b0; cp0_bev_i = 1'b0; cp0_exl_i = 1'b0; cp0_epc_i = '0;
    #2;
    total++; if ({commit_valid_o, exc_valid_o, eret_o, flush_o, bd_o, exc_code_o} !== 10'b0)
      $display("FAIL reset_ctrl: got %b want 0", {commit_valid_o, exc_valid_o, eret_o, flush_o, bd_o, exc_code_o}); else passed++;
    total++; if ({epc_o, badvaddr_o, target_pc_o} !== 96'b0) $display("FAIL reset_data: got %h want 0", {epc_o, badvaddr_o, target_pc_o}); else passed++;
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    total++; if ({ready_o, flush_o} !== 2'b10) $display("FAIL reset_release: got %b want 10", {ready_o, flush_o}); else passed++;
  endtask

  task automatic test_commit();
    exercise(32'h0, 32'h8000_1000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "commit");
    exercise(32'h7FF8_0000, 32'h8000_1004, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "ignored_bits");
  endtask

  task automatic test_exception();
    exercise(32'h44, 32'h8000_2004, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h0, "ov_sys");
    total++; if ({exc_code_o, epc_o, bd_o, target_pc_o} !== {5'h0C, 32'h8000_2000, 1'b1, 32'h8000_0180})
      $display("FAIL ov_sys_const: got %h %h %b %h want 0c 80002000 1 80000180", exc_code_o, epc_o, bd_o, target_pc_o); else passed++;
    exercise(32'h2, 32'hBFC0_0003, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, "fetch_adel_bev");
    total++; if ({exc_code_o, badvaddr_o, target_pc_o} !== {5'h04, 32'hBFC0_0003, 32'hBFC0_0380})
      $display("FAIL fetch_adel_const: got %h %h %h want 04 bfc00003 bfc00380", exc_code_o, badvaddr_o, target_pc_o); else passed++;
  endtask

  task automatic test_tlb();
    exercise(32'h1000, 32'h8000_4000, 32'h0040_0010, 1'b0, 1'b0, 1'b0, 32'h0, "dtlb_refill_exl0");
`ifdef EXC_TLB_EN
    total++; if ({exc_code_o, badvaddr_o, target_pc_o} !== {5'h02, 32'h0040_0010, 32'h8000_0000})
      $display("FAIL dtlb_exl0_const: got %h %h %h want 02 00400010 80000000", exc_code_o, badvaddr_o, target_pc_o); else passed++;
    exercise(32'h1000, 32'h8000_4000, 32'h0040_0010, 1'b0, 1'b0, 1'b1, 32'h0, "dtlb_refill_exl1");
    total++; if (target_pc_o !== 32'h8000_0180) $display("FAIL dtlb_exl1_const: got %h want 80000180", target_pc_o); else passed++;
`endif
  endtask

  task automatic test_eret();
    exercise(32'h10, 32'h8000_5000, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_3000, "eret");
    total++; if (target_pc_o !== 32'h8000_3000) $display("FAIL eret_const: got %h want 80003000", target_pc_o); else passed++;
    exercise(32'h8000_0000, 32'h8000_6000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h8000_3000, "refetch");
  endtask

  task automatic test_back_to_back();
    valid_i = 1'b1; exception_vector_i = 32'h0; pc_i = 32'h8000_7000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if ({commit_valid_o, ready_o} !== 2'b11) $display("FAIL b2b_commit%0d: got %b want 11", k, {commit_valid_o, ready_o}); else passed++;
    end
    valid_i = 1'b0;
    @(negedge clk);
    total++; if (commit_valid_o !== 1'b0) $display("FAIL b2b_idle: got %b want 0", commit_valid_o); else passed++;
    exercise(32'h20, 32'h8000_7100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "b2b_ri");
    exercise(32'h80, 32'h8000_7200, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, "b2b_tr");
  endtask

  task automatic test_reset_mid_flush();
    valid_i = 1'b1; exception_vector_i = 32'h40; pc_i = 32'h8000_8000; bd_i = 1'b0; cp0_bev_i = 1'b0;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    total++; if (flush_o !== 1'b1) $display("FAIL midflush_pre: got %b want 1", flush_o); else passed++;
    resetn = 1'b0;
    #1;
    total++; if ({flush_o, exc_valid_o, eret_o, commit_valid_o, exc_code_o, target_pc_o, epc_o} !== '0)
      $display("FAIL midflush_reset: got %b %b %h %h want 0", flush_o, exc_valid_o, exc_code_o, target_pc_o); else passed++;
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if ({ready_o, flush_o, exc_valid_o, eret_o} !== 4'b1000)
        $display("FAIL midflush_after%0d: got %b want 1000", k, {ready_o, flush_o, exc_valid_o, eret_o}); else passed++;
    end
  endtask

  task automatic test_random();
    logic [31:0] vec;
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 4))
        0: vec = 32'h0;
        1: vec = 32'h1 << $urandom_range(0, 31);
        2: vec = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
        3: vec = $urandom & $urandom & $urandom;
        default: vec = $urandom & 32'h7FF8_0000;
      endcase
      exercise(vec, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), $urandom,
               $sformatf("rand%0d_%h", k, vec));
    end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_exception();
    test_tlb();
    test_eret();
    test_back_to_back();
    test_reset_mid_flush();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
